mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle MIPS control unit that sits directly upstream of the 32-bit ALU.
- Moore FSM that sequences fetch/decode/execute/memory/writeback for the datapath.
- Drives every datapath mux and enable, including the ALU's 3-bit `choose` code, which it decodes from opcode/funct.
- Consumes the ALU `zero` flag to resolve branches.

Parameters:
- `MEM_WAIT_EN`, 1, when 1, FETCH/MEMREAD/MEMWRITE hold until `mem_ready`=1; when 0, `mem_ready` is ignored and treated as 1.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `opcode`  input  6  IR[31:26]; valid from DECODE onward.
- `funct`  input  6  IR[5:0].
- `zero`  input  1  ALU zero flag.
- `mem_ready`  input  1  memory access complete this cycle.
- `pc_en`  output  1  PC load enable (`pc_write` | (`branch` & `zero`)).
- `iord`  output  1  0 = PC addresses memory, 1 = ALUOut.
- `mem_write`  output  1  memory write strobe.
- `ir_write`  output  1  instruction register load.
- `reg_dst`  output  1  0 = rt, 1 = rd.
- `mem_to_reg`  output  1  0 = ALUOut, 1 = MDR.
- `reg_write`  output  1  register file write.
- `alu_src_a`  output  1  0 = PC, 1 = A.
- `alu_src_b`  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `pc_src`  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_choose`  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 100 slt.
- `state`  output  4  current state, for debug/verification.

Behaviour:
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- **Reset:**
  - `state` <= FETCH on any edge with `rst`=1; this overrides all transitions, including mid-instruction (no partial writeback afterward).
  - While `rst`=1, all outputs are forced to 0 (`state` output reflects the register).
- **Output defaults:** every output not listed for a state is 0 (`alu_choose` defaults to 010). Outputs are purely combinational from `state` (plus `funct`, `zero`, `mem_ready` where stated).
- **Per-state outputs:**
  - FETCH: `alu_src_b`=01, `alu_choose`=010, `pc_src`=00. `ir_write` and `pc_write` are asserted only when `mem_ready`=1; hold in FETCH while `mem_ready`=0.
  - DECODE: `alu_src_b`=11, `alu_choose`=010.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_choose`=010.
  - MEMREAD: `iord`=1; hold while `mem_ready`=0.
  - MEMWB: `mem_to_reg`=1, `reg_write`=1.
  - MEMWRITE: `iord`=1, `mem_write`=1; hold while `mem_ready`=0 (`mem_write` stays high throughout the hold).
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_choose` from `funct`:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 100
    - any other funct -> 010
  - ALUWB: `reg_dst`=1, `reg_write`=1.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_choose`=110, `pc_src`=01, `branch`=1 (so `pc_en`=`zero`).
  - ADDIEXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_choose`=010.
  - ADDIWB: `reg_write`=1 (`reg_dst`=0, `mem_to_reg`=0).
  - JUMP: `pc_src`=10, `pc_write`=1.
- **Transitions:**
  - FETCH -> DECODE when `mem_ready`=1.
  - DECODE dispatches on `opcode`:
    - 100011 (lw) -> MEMADR
    - 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEXEC
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH (treated as NOP; no enables asserted).
  - MEMADR -> MEMREAD for lw, -> MEMWRITE for sw.
  - MEMREAD -> MEMWB when `mem_ready`=1.
  - MEMWRITE -> FETCH when `mem_ready`=1.
  - EXEC -> ALUWB; ADDIEXEC -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - Undefined state codes 12–15 -> FETCH.
- **Cycle counts** (`mem_ready` constantly 1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.

Test Plan:
- **lw:** `rst` 1 cycle then `opcode`=100011, `mem_ready`=1 -> `state` 0,1,2,3,4,0. MEMWB shows `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. FETCH shows `pc_en`=1, `ir_write`=1, `alu_choose`=010.
- **R-type sweep:** `opcode`=000000, funct ∈ {100000, 100010, 100100, 100101, 101010, 111111} -> EXEC `alu_choose` = 010, 110, 000, 001, 100, 010 respectively. ALUWB shows `reg_dst`=1, `reg_write`=1.
- **beq:** `opcode`=000100 with `zero`=1 -> BRANCH `pc_en`=1, `pc_src`=01, `alu_choose`=110. With `zero`=0 -> `pc_en`=0. Both cases return to FETCH the next cycle.
- **Memory stall:** `opcode`=101011 with `mem_ready`=0 for 3 cycles in MEMWRITE -> `state` stays 5 for 4 cycles total with `mem_write`=1 and `iord`=1, then FETCH. `mem_ready`=0 in FETCH -> `ir_write`=0, `pc_en`=0, state stays 0.
- **Reset mid-operation:** `rst`=1 asserted while in ALUWB -> all outputs 0 that cycle, `state`=0 the next cycle, and no `reg_write` pulse after `rst` falls until a new instruction completes.
- **Illegal opcode:** `opcode`=111111 -> DECODE then FETCH; `reg_write`, `mem_write` and `pc_en` stay 0 after FETCH. Separately, j (`opcode`=000010) -> JUMP shows `pc_src`=10, `pc_en`=1.

Source files
------------

// File: rtl/mc_control_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// master: controller side (consumes opcode/funct/zero/mem_ready, drives
//         every mux select, enable and the ALU operation code).
// slave : datapath side (mirror image of master).
// Ports : opcode[5:0], funct[5:0], zero, mem_ready (datapath -> control);
//         pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//         alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_choose[2:0],
//         state[3:0] (control -> datapath).
interface mc_control_if;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned CHOOSE_W = 3;
    localparam int unsigned STATE_W  = 4;

    logic [OP_W-1:0]     opcode;
    logic [OP_W-1:0]     funct;
    logic                zero;
    logic                mem_ready;

    logic                pc_en;
    logic                iord;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [SEL_W-1:0]    pc_src;
    logic [CHOOSE_W-1:0] alu_choose;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_choose, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_choose, state
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch / decode /
// execute / memory / writeback and driving all datapath selects, enables
// and the ALU operation code.
// Ports : clk, rst (synchronous, active high); bus (mc_control_if.master)
//         carrying opcode/funct/zero/mem_ready in and all controls out.
// MEM_WAIT_EN=1 makes FETCH/MEMREAD/MEMWRITE wait for mem_ready.
module mc_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    mc_control_if.master bus
);
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned CHOOSE_W = 3;
    localparam int unsigned OP_W     = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [CHOOSE_W-1:0] ALU_ADD = 3'b010;
    localparam logic [CHOOSE_W-1:0] ALU_SUB = 3'b110;
    localparam logic [CHOOSE_W-1:0] ALU_AND = 3'b000;
    localparam logic [CHOOSE_W-1:0] ALU_OR  = 3'b001;
    localparam logic [CHOOSE_W-1:0] ALU_SLT = 3'b100;

    state_t state_q;
    state_t state_d;
    logic   ready;
    logic   pc_write;
    logic   branch;

    // With waiting disabled every memory access completes in one cycle.
    assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // R-type funct to ALU operation; unknown functs fall back to add.
    function automatic logic [CHOOSE_W-1:0] funct_to_choose(input logic [OP_W-1:0] f);
        case (f)
            6'b100000: funct_to_choose = ALU_ADD;
            6'b100010: funct_to_choose = ALU_SUB;
            6'b100100: funct_to_choose = ALU_AND;
            6'b100101: funct_to_choose = ALU_OR;
            6'b101010: funct_to_choose = ALU_SLT;
            default:   funct_to_choose = ALU_ADD;
        endcase
    endfunction

    // State register; reset wins over any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      state_d = S_MEMREAD;
                else if (bus.opcode == OP_SW) state_d = S_MEMWRITE;
                else                          state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
            S_EXEC:     state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode; everything is forced low while reset is held.
    always_comb begin
        pc_write       = 1'b0;
        branch         = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_src     = 2'b00;
        bus.alu_choose = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b = 2'b01;
                bus.ir_write  = ready;
                pc_write      = ready;
            end
            S_DECODE:   bus.alu_src_b = 2'b11;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMREAD:  bus.iord = 1'b1;
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_choose = funct_to_choose(bus.funct);
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_choose = ALU_SUB;
                bus.pc_src     = 2'b01;
                branch         = 1'b1;
            end
            S_ADDIEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDIWB:   bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src = 2'b10;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write       = 1'b0;
            branch         = 1'b0;
            bus.iord       = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
            bus.reg_write  = 1'b0;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = 2'b00;
            bus.pc_src     = 2'b00;
            bus.alu_choose = 3'b000;
        end
    end

    assign bus.pc_en = pc_write | (branch & bus.zero);
    assign bus.state = state_q;
endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control: walks lw, R-type funct sweep,
// beq taken/not-taken, sw with memory stall, fetch stall, mid-instruction
// reset, illegal opcode and jump, comparing against hand-derived values.
module tb_mc_control;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mc_control_if bus ();

    mc_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point lands 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [5:0] fn_tab [6];
    logic [2:0] ch_tab [6];

    initial begin
        checks   = 0;
        failures = 0;
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        ch_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b100,    3'b010};

        rst           = 1'b1;
        bus.opcode    = 6'b100011;
        bus.funct     = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset: state 0 and all controls low, ALU code included.
        tick();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_pc_en", 32'(bus.pc_en), 32'd0);
        check("rst_ir_write", 32'(bus.ir_write), 32'd0);
        check("rst_alu_choose", 32'(bus.alu_choose), 32'd0);
        check("rst_alu_src_b", 32'(bus.alu_src_b), 32'd0);
        rst = 1'b0;
        #1;

        // lw: FETCH controls, then 1,2,3,4,0.
        check("fetch_pc_en", 32'(bus.pc_en), 32'd1);
        check("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        check("fetch_alu_choose", 32'(bus.alu_choose), 32'd2);
        check("fetch_alu_src_b", 32'(bus.alu_src_b), 32'd1);
        tick();
        check("lw_decode", 32'(bus.state), 32'd1);
        check("lw_decode_src_b", 32'(bus.alu_src_b), 32'd3);
        tick();
        check("lw_memadr", 32'(bus.state), 32'd2);
        check("lw_memadr_src", 32'({bus.alu_src_a, bus.alu_src_b}), 32'b110);
        tick();
        check("lw_memread", 32'(bus.state), 32'd3);
        check("lw_memread_iord", 32'(bus.iord), 32'd1);
        tick();
        check("lw_memwb", 32'(bus.state), 32'd4);
        check("lw_memwb_ctl", 32'({bus.reg_write, bus.mem_to_reg, bus.reg_dst}), 32'b110);
        tick();
        check("lw_back_fetch", 32'(bus.state), 32'd0);

        // R-type funct sweep.
        bus.opcode = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            bus.funct = fn_tab[i];
            tick();
            tick();
            check($sformatf("rt%0d_exec", i), 32'(bus.state), 32'd6);
            check($sformatf("rt%0d_choose", i), 32'(bus.alu_choose), 32'(ch_tab[i]));
            tick();
            check($sformatf("rt%0d_aluwb", i), 32'({bus.state, bus.reg_dst, bus.reg_write}), 32'h1F);
            tick();
            check($sformatf("rt%0d_fetch", i), 32'(bus.state), 32'd0);
        end

        // beq taken then not taken.
        bus.opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = 1'(z);
            tick();
            tick();
            check($sformatf("beq%0d_state", z), 32'(bus.state), 32'd8);
            check($sformatf("beq%0d_pc_en", z), 32'(bus.pc_en), 32'(z));
            check($sformatf("beq%0d_pc_src", z), 32'(bus.pc_src), 32'd1);
            check($sformatf("beq%0d_choose", z), 32'(bus.alu_choose), 32'd6);
            tick();
            check($sformatf("beq%0d_fetch", z), 32'(bus.state), 32'd0);
        end
        bus.zero = 1'b0;

        // sw with three stalled cycles in MEMWRITE.
        bus.opcode = 6'b101011;
        tick();
        tick();
        check("sw_memadr", 32'(bus.state), 32'd2);
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sw_hold%0d", i), 32'({bus.state, bus.mem_write, bus.iord}), 32'h17);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("sw_hold3", 32'({bus.state, bus.mem_write, bus.iord}), 32'h17);
        tick();
        check("sw_fetch", 32'(bus.state), 32'd0);

        // FETCH stall: no IR load, no PC update, stays in FETCH.
        bus.mem_ready = 1'b0;
        #1;
        check("fstall_ir_write", 32'(bus.ir_write), 32'd0);
        check("fstall_pc_en", 32'(bus.pc_en), 32'd0);
        tick();
        check("fstall_state", 32'(bus.state), 32'd0);
        bus.mem_ready = 1'b1;

        // Reset while in ALUWB.
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100000;
        tick();
        tick();
        tick();
        check("mrst_in_aluwb", 32'(bus.state), 32'd7);
        rst = 1'b1;
        #1;
        check("mrst_reg_write", 32'(bus.reg_write), 32'd0);
        check("mrst_reg_dst", 32'(bus.reg_dst), 32'd0);
        tick();
        check("mrst_state", 32'(bus.state), 32'd0);
        rst = 1'b0;

        // Illegal opcode right after reset: DECODE then FETCH, no writes.
        bus.opcode = 6'b111111;
        #1;
        check("ill_fetch_reg_write", 32'(bus.reg_write), 32'd0);
        tick();
        check("ill_decode", 32'(bus.state), 32'd1);
        check("ill_decode_ctl", 32'({bus.reg_write, bus.mem_write, bus.pc_en}), 32'd0);
        tick();
        check("ill_fetch", 32'(bus.state), 32'd0);
        check("ill_fetch_reg_write2", 32'(bus.reg_write), 32'd0);

        // Jump.
        bus.opcode = 6'b000010;
        tick();
        tick();
        check("j_state", 32'(bus.state), 32'd11);
        check("j_pc_src", 32'(bus.pc_src), 32'd2);
        check("j_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
        check("j_fetch", 32'(bus.state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
